frame_streamer: RTL and testbench

FRAME_STREAMER -- requirements
Module: frame_streamer

---
 rtl/frame_streamer.sv | 123 ++++++++++++
 tb/tb_frame_streamer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_streamer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// frame_streamer: two-bank frame buffer that replays every complete frame as
// one contiguous vld_out burst.                               Rev 1.0
// ---------------------------------------------------------------------------
module frame_streamer #(
  parameter int NO_CH         = 2,
  parameter int LOG2_IMG_SIZE = 10,
  parameter int THROUGHPUT    = 1,
  parameter int GAP           = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_vld,
  output logic                             in_rdy,
  input  logic [THROUGHPUT-1:0][NO_CH-1:0] in_data,
  output logic                             vld_out,
  output logic [THROUGHPUT-1:0][NO_CH-1:0] data_out
);

  localparam int BEATS  = (2 ** LOG2_IMG_SIZE) / THROUGHPUT;
  localparam int AW_RAW = LOG2_IMG_SIZE - $clog2(THROUGHPUT);
  localparam int AW     = (AW_RAW > 1) ? AW_RAW : 1;
  localparam int GW     = $clog2(GAP + 1);
  localparam logic [AW-1:0] LAST_BEAT = AW'(BEATS - 1);
  // The IDLE cycle and the first read cycle also show vld_out=0, so leaving
  // here after GAP-1 cycles yields GAP idle output cycles between bursts.
  localparam logic [GW-1:0] GAP_EXIT = GW'((GAP > 1) ? GAP - 2 : 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BURST    = 2'd1,
    GAP_WAIT = 2'd2
  } state_t;

  logic [THROUGHPUT-1:0][NO_CH-1:0] mem_q [2][BEATS];

  state_t                           state_q;
  logic [AW-1:0]                    wr_cnt_q;
  logic [AW-1:0]                    rd_cnt_q;
  logic [GW-1:0]                    gap_cnt_q;
  logic                             wr_bank_q;
  logic                             rd_bank_q;
  logic [1:0]                       full_q;
  logic [1:0]                       full_d;
  logic                             vld_out_q;
  logic [THROUGHPUT-1:0][NO_CH-1:0] data_out_q;

  logic accept;
  logic wr_last;
  logic rd_last;

  assign in_rdy   = !full_q[wr_bank_q] && !rst;
  assign accept   = in_vld && in_rdy;
  assign wr_last  = accept && (wr_cnt_q == LAST_BEAT);
  assign rd_last  = (state_q == BURST) && (rd_cnt_q == LAST_BEAT);
  assign vld_out  = vld_out_q;
  assign data_out = data_out_q;

  // Writer and reader always target different banks, so set and clear never collide.
  always_comb begin
    full_d = full_q;
    if (wr_last) full_d[wr_bank_q] = 1'b1;
    if (rd_last) full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      full_q    <= '0;
    end else begin
      full_q <= full_d;
      if (accept) begin
        wr_cnt_q <= wr_last ? '0 : wr_cnt_q + 1'b1;
        if (wr_last) wr_bank_q <= ~wr_bank_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_bank_q][wr_cnt_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      rd_bank_q  <= 1'b0;
      vld_out_q  <= 1'b0;
      data_out_q <= '0;
    end else begin
      vld_out_q <= (state_q == BURST);
      case (state_q)
        IDLE: begin
          if (full_q[rd_bank_q]) begin
            state_q  <= BURST;
            rd_cnt_q <= '0;
          end
        end
        BURST: begin
          data_out_q <= mem_q[rd_bank_q][rd_cnt_q];
          if (rd_last) begin
            rd_cnt_q  <= '0;
            rd_bank_q <= ~rd_bank_q;
            gap_cnt_q <= '0;
            state_q   <= GAP_WAIT;
          end else begin
            rd_cnt_q <= rd_cnt_q + 1'b1;
          end
        end
        GAP_WAIT: begin
          if (gap_cnt_q == GAP_EXIT) state_q <= IDLE;
          else gap_cnt_q <= gap_cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_streamer.sv
`default_nettype none
// Bench for frame_streamer: 16-beat frames, single-lane and two-lane builds.
module tb_frame_streamer;

  localparam int BEATS = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_vld;
  logic            in_rdy;
  logic [0:0][7:0] in_data;
  logic            vld_out;
  logic [0:0][7:0] data_out;

  logic            in_vld2;
  logic            in_rdy2;
  logic [1:0][7:0] in_data2;
  logic            vld_out2;
  logic [1:0][7:0] data_out2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       vld_i;
    logic [7:0] data_i;
    logic       rdy_e;
    logic       vld_e;
    logic [7:0] data_e;
  } vec_t;

  vec_t vecs [36];

  always #5 clk = ~clk;

  frame_streamer #(.NO_CH(8), .LOG2_IMG_SIZE(4), .THROUGHPUT(1), .GAP(2)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
    .vld_out(vld_out), .data_out(data_out)
  );

  frame_streamer #(.NO_CH(8), .LOG2_IMG_SIZE(4), .THROUGHPUT(2), .GAP(2)) dut2 (
    .clk(clk), .rst(rst), .in_vld(in_vld2), .in_rdy(in_rdy2), .in_data(in_data2),
    .vld_out(vld_out2), .data_out(data_out2)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_vld   = 1'b0;
    in_data  = '0;
    in_vld2  = 1'b0;
    in_data2 = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic feed(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      in_vld  = 1'b1;
      in_data = 8'(base + i);
      tick();
    end
    in_vld = 1'b0;
  endtask

  task automatic expect_frame(input int base, input string name, input int max_wait,
                              output int waited);
    waited = 0;
    while (!vld_out && waited < max_wait) begin
      tick();
      waited++;
    end
    check({name, " start"}, int'(vld_out), 1);
    if (vld_out) begin
      for (int i = 0; i < BEATS; i++) begin
        if (i > 0) tick();
        check({name, " vld"}, int'(vld_out), 1);
        check({name, " data"}, int'(data_out), base + i);
      end
      tick();
      check({name, " end"}, int'(vld_out), 0);
    end
  endtask

  int  w, hits, sent, rcvd, run, gap_len, bursts;
  logic rdy_now, seen_drop, rose_seen;

  initial begin
    for (int k = 0; k < 36; k++) begin
      vecs[k].vld_i  = (k < 16);
      vecs[k].data_i = (k < 16) ? 8'(k) : 8'd0;
      vecs[k].rdy_e  = 1'b1;
      vecs[k].vld_e  = (k >= 17 && k <= 32);
      vecs[k].data_e = (k < 17) ? 8'd0 : ((k <= 32) ? 8'(k - 17) : 8'd15);
    end

    // Reset state
    rst = 1'b1; in_vld = 1'b0; in_data = '0; in_vld2 = 1'b0; in_data2 = '0;
    tick();
    check("rst rdy during", int'(in_rdy), 0);
    check("rst vld", int'(vld_out), 0);
    check("rst data", int'(data_out), 0);
    rst = 1'b0;
    #1;
    check("rdy after rst", int'(in_rdy), 1);

    // Single frame, table driven
    for (int k = 0; k < 36; k++) begin
      in_vld  = vecs[k].vld_i;
      in_data = vecs[k].data_i;
      check("tbl rdy", int'(in_rdy), int'(vecs[k].rdy_e));
      tick();
      check("tbl vld", int'(vld_out), int'(vecs[k].vld_e));
      check("tbl data", int'(data_out), int'(vecs[k].data_e));
    end
    in_vld = 1'b0;

    // Bursty input: in_vld 1,0,1,0...
    do_reset();
    for (int i = 0; i < 31; i++) begin
      in_vld  = (i % 2 == 0);
      in_data = 8'(i / 2);
      tick();
      check("bursty no early out", int'(vld_out), 0);
    end
    in_vld = 1'b0;
    expect_frame(0, "bursty", 40, w);
    check("bursty latency", w, 2);

    // Back-pressure with three frames; also bursts and gaps between buffered frames
    do_reset();
    sent = 0; rcvd = 0; run = 0; gap_len = 0; bursts = 0;
    seen_drop = 1'b0; rose_seen = 1'b0;
    for (int cyc = 0; cyc < 300 && rcvd < 48; cyc++) begin
      in_vld  = (sent < 48);
      in_data = 8'(sent);
      rdy_now = in_rdy;
      if (in_vld && sent < 32) check("bp rdy early", int'(in_rdy), 1);
      if (sent == 32 && !seen_drop) begin
        check("bp rdy drop", int'(in_rdy), 0);
        seen_drop = 1'b1;
      end
      tick();
      if (rdy_now && in_vld) sent++;
      if (vld_out) begin
        check("bp data", int'(data_out), rcvd);
        rcvd++;
        run++;
        if (run == 1 && bursts > 0) check("bp gap", gap_len, 2);
        gap_len = 0;
      end else begin
        if (run > 0) begin
          check("bp burst len", run, 16);
          bursts++;
        end
        run = 0;
        gap_len++;
      end
      if (!rdy_now && in_rdy && !rose_seen) begin
        rose_seen = 1'b1;
        check("bp rdy rise", rcvd, 16);
      end
    end
    in_vld = 1'b0;
    check("bp rcvd", rcvd, 48);
    check("bp sent", sent, 48);
    check("bp drop seen", int'(seen_drop), 1);
    check("bp rise seen", int'(rose_seen), 1);
    check("bp bursts", bursts, 2);
    tick();
    check("bp final low", int'(vld_out), 0);

    // Reset mid-burst at output beat 7, then a partial fill discarded by reset
    do_reset();
    feed(0, 16);
    w = 0;
    while (!(vld_out && data_out == 8'd7) && w < 40) begin
      tick();
      w++;
    end
    check("rst beat7 seen", int'(vld_out && data_out == 8'd7), 1);
    rst = 1'b1;
    #1;
    check("rst mid rdy", int'(in_rdy), 0);
    tick();
    check("rst mid vld", int'(vld_out), 0);
    check("rst mid data", int'(data_out), 0);
    rst = 1'b0;
    #1;
    check("rst mid rdy after", int'(in_rdy), 1);
    hits = 0;
    repeat (30) begin
      tick();
      if (vld_out) hits++;
    end
    check("rst residual", hits, 0);
    feed(200, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    feed(100, 16);
    expect_frame(100, "post rst", 40, w);
    check("post rst latency", w, 2);

    // Two-lane build
    do_reset();
    check("t2 rdy", int'(in_rdy2), 1);
    for (int i = 0; i < 8; i++) begin
      in_vld2     = 1'b1;
      in_data2[0] = 8'(2 * i);
      in_data2[1] = 8'(2 * i + 1);
      tick();
    end
    in_vld2 = 1'b0;
    w = 0;
    while (!vld_out2 && w < 20) begin
      tick();
      w++;
    end
    check("t2 latency", w, 2);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      check("t2 vld", int'(vld_out2), 1);
      check("t2 lane0", int'(data_out2[0]), 2 * i);
      check("t2 lane1", int'(data_out2[1]), 2 * i + 1);
    end
    tick();
    check("t2 end", int'(vld_out2), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
